// File: rtl/sseg_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sseg_scan_driver                                       |
// | Description : Time-multiplexed seven-segment scanner. A divider sets |
// |               how long each digit is lit; new data is captured into  |
// |               a pending register and committed only at the frame     |
// |               boundary so a scan never shows mixed old/new digits.   |
// | Option      : define SSEG_LEADING_ZERO_BLANK_EN to blank leading     |
// |               zero digits (digit 0 is never blanked).                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sseg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [4*NUM_DIGITS-1:0]   value_i,
    input  logic [NUM_DIGITS-1:0]     dp_i,
    input  logic                      load_i,
    output logic                      pending_o,
    output logic [6:0]                sseg_o,
    output logic                      dp_o,
    output logic [NUM_DIGITS-1:0]     an_o,
    output logic                      frame_o
);

    localparam int C_DIV_W = $clog2(REFRESH_DIV);
    localparam int C_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [C_DIV_W-1:0] C_DIV_MAX = C_DIV_W'(REFRESH_DIV - 1);
    localparam logic [C_IDX_W-1:0] C_IDX_MAX = C_IDX_W'(NUM_DIGITS - 1);

    logic [C_DIV_W-1:0]        r_div;
    logic [C_IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0]   r_disp_val;
    logic [NUM_DIGITS-1:0]     r_disp_dp;
    logic [4*NUM_DIGITS-1:0]   r_pend_val;
    logic [NUM_DIGITS-1:0]     r_pend_dp;
    logic                      r_pending;
    logic [6:0]                r_sseg;
    logic                      r_dp;
    logic [NUM_DIGITS-1:0]     r_an;

    logic                      w_div_wrap;
    logic                      w_idx_last;
    logic                      w_frame;
    logic [3:0]                w_nib;
    logic                      w_dp_bit;
    logic [NUM_DIGITS-1:0]     w_an;
    logic [6:0]                w_seg;
    logic                      w_blank;

    assign w_div_wrap = (r_div == C_DIV_MAX);
    assign w_idx_last = (r_idx == C_IDX_MAX);
    assign w_frame    = w_div_wrap & w_idx_last;

    assign frame_o   = w_frame;
    assign pending_o = r_pending;
    assign sseg_o    = r_sseg;
    assign dp_o      = r_dp;
    assign an_o      = r_an;

    // Divider sets the dwell time per digit; the index steps on each wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (w_div_wrap) begin
            r_div <= '0;
            r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Capture into pending; commit to the display register only at frame end.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_disp_val <= '0;
            r_disp_dp  <= '0;
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_pending  <= 1'b0;
        end else if (w_frame) begin
            // A load landing on the boundary bypasses pending entirely.
            if (load_i) begin
                r_disp_val <= value_i;
                r_disp_dp  <= dp_i;
            end else if (r_pending) begin
                r_disp_val <= r_pend_val;
                r_disp_dp  <= r_pend_dp;
            end
            r_pending <= 1'b0;
        end else if (load_i) begin
            r_pend_val <= value_i;
            r_pend_dp  <= dp_i;
            r_pending  <= 1'b1;
        end
    end

    // Select the nibble, decimal point and anode for the current index.
    always_comb begin
        w_nib    = 4'h0;
        w_dp_bit = 1'b0;
        w_an     = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == C_IDX_W'(i)) begin
                w_nib    = r_disp_val[i*4 +: 4];
                w_dp_bit = r_disp_dp[i];
                w_an[i]  = 1'b0;
            end
        end
    end

    // Hex to active-low gfedcba segment decode.
    always_comb begin
        w_seg = 7'b1111111;
        case (w_nib)
            4'h0: w_seg = 7'b1000000;
            4'h1: w_seg = 7'b1111001;
            4'h2: w_seg = 7'b0100100;
            4'h3: w_seg = 7'b0110000;
            4'h4: w_seg = 7'b0011001;
            4'h5: w_seg = 7'b0010010;
            4'h6: w_seg = 7'b0000010;
            4'h7: w_seg = 7'b1111000;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0010000;
            4'hA: w_seg = 7'b0001000;
            4'hB: w_seg = 7'b0000011;
            4'hC: w_seg = 7'b1000110;
            4'hD: w_seg = 7'b0100001;
            4'hE: w_seg = 7'b0000110;
            4'hF: w_seg = 7'b0001110;
            default: w_seg = 7'b1111111;
        endcase
    end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    logic w_upper_zero;

    // Blank the current digit if it and every digit above it are zero.
    always_comb begin
        w_upper_zero = 1'b1;
        w_blank      = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_upper_zero = w_upper_zero && (r_disp_val[i*4 +: 4] == 4'h0);
            if ((i != 0) && (r_idx == C_IDX_W'(i)) && w_upper_zero) begin
                w_blank = 1'b1;
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    // Register the drive pins so they change glitch-free one cycle after the index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sseg <= 7'b1111111;
            r_dp   <= 1'b1;
            r_an   <= '1;
        end else begin
            r_sseg <= w_blank ? 7'b1111111 : w_seg;
            r_dp   <= ~w_dp_bit;
            r_an   <= w_an;
        end
    end

endmodule
`default_nettype wire

// File: doc/sseg_scan_driver.md
SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

Interface
REQ-001 SHALL provide parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 SHALL provide parameter REFRESH_DIV, default 50000: clock cycles each digit is lit, legal range 2..2^20.
REQ-003 SHALL provide port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_ni, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL provide port value_i, input, 4*NUM_DIGITS bits: hex nibbles, nibble 0 (bits 3:0) = rightmost digit.
REQ-006 SHALL provide port dp_i, input, NUM_DIGITS bits: decimal point request per digit, 1 = lit.
REQ-007 SHALL provide port load_i, input, 1 bit: single-cycle request to capture value_i/dp_i.
REQ-008 SHALL provide port pending_o, output, 1 bit: captured data is waiting for the frame boundary.
REQ-009 SHALL provide port sseg_o, output, 7 bits: segments gfedcba, active-low.
REQ-010 SHALL provide port dp_o, output, 1 bit: decimal point, active-low.
REQ-011 SHALL provide port an_o, output, NUM_DIGITS bits: digit enables, active-low, one-hot-zero.
REQ-012 SHALL provide port frame_o, output, 1 bit: one-cycle pulse at the end of each full scan.

Function
REQ-013 SHALL run a divider counting 0..REFRESH_DIV-1 and wrapping to 0.
REQ-014 SHALL advance the digit index (0..NUM_DIGITS-1) on each divider wrap; index NUM_DIGITS-1 wraps to 0.
REQ-015 SHALL assert frame_o for exactly the cycle in which the index wraps from NUM_DIGITS-1 to 0; with NUM_DIGITS=1, every divider wrap.
REQ-016 SHALL register sseg_o, dp_o and an_o so they reflect the current index one cycle after it changes; exactly one an_o bit is low outside reset.
REQ-017 SHALL decode nibbles active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-018 SHALL drive dp_o = ~dp bit of the displayed digit.
REQ-019 SHALL display from a display register, not from value_i directly (no tearing mid-frame).
REQ-020 SHALL on load_i capture value_i/dp_i into a pending register and set pending_o the next cycle.
REQ-021 SHALL on a frame_o cycle with pending_o=1 copy pending into the display register and clear pending_o.
REQ-022 SHALL when load_i coincides with a frame_o cycle commit that cycle's value_i/dp_i directly to the display register, leaving pending_o=0.
REQ-023 SHALL let a later load_i overwrite an uncommitted pending value (last write wins).

Reset
REQ-024 SHALL, while rst_ni=0, force an_o=all ones, sseg_o=1111111, dp_o=1, frame_o=0, pending_o=0, divider=0, index=0, display and pending registers=0.
REQ-025 SHALL after rst_ni deasserts begin scanning at index 0, so the first lit digit shows 0 with decimal point off; reset mid-frame discards pending data.

Configuration
REQ-026 SHALL, with macro SSEG_LEADING_ZERO_BLANK_EN defined, blank (sseg_o=1111111) every zero digit above the most significant non-zero digit, never blanking digit 0; dp_o still follows dp_i, an_o unchanged.
REQ-027 SHALL, without SSEG_LEADING_ZERO_BLANK_EN, display every digit including leading zeros.

Verification
REQ-028 SHALL cover: NUM_DIGITS=4, REFRESH_DIV=4, reset release -> an_o walks 1110,1101,1011,0111 every 4 cycles; frame_o pulses every 16 cycles.
REQ-029 SHALL cover: load_i with value_i=16'h12AF mid-frame -> pending_o=1 until next frame_o, then digits show F,A,2,1 (0001110,0001000,0100100,1111001).
REQ-030 SHALL cover: load_i on a frame_o cycle with 16'h0BEE -> next frame shows E,E,b,0 with pending_o never asserted.
REQ-031 SHALL cover: two loads 16'h1111 then 16'h2222 in one frame -> only 2222 is displayed.
REQ-032 SHALL cover: with SSEG_LEADING_ZERO_BLANK_EN, value 16'h0040 -> digits 3 and 2 blank, digit 1 shows 4, digit 0 shows 0; value 0 -> only digit 0 lit as 0.
REQ-033 SHALL cover: rst_ni low mid-frame with pending_o=1 -> outputs return to reset values asynchronously; after release display shows 0000, pending_o=0.
